alu_issue_arb: RTL

- Shares one 3-stage pipelined ALU (REG_WIDTH datapath, single `pipe_active` enable for all stages) between NUM_REQ requesters.
- Arbitration is round-robin. The block tracks valid/tag per stage, handles response backpressure, and drives the ALU enable.
- Ops overlap back-to-back only when they share ctrl/cin. The ALU needs ctrl/cin stable while any op sits in its first two stages, so a ctrl/cin change forces a drain.

---
 rtl/alu_pkg.sv | 18 +
 rtl/rr_arb.sv | 28 ++
 rtl/alu_issue_arb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control word width, the ctrl encodings used by the
// issue arbiter's clients, and the operand bundle type.
package alu_pkg;

    localparam int ALU_CTRL_W = 8;
    localparam int ALU_DATA_W = 16;

    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_ADD = 8'h2C;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_XOR = 8'h04;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic [ALU_CTRL_W-1:0] ctrl;
        logic                  cin;
    } alu_op_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo NUM_REQ.
module rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [TAG_W-1:0]   ptr_i,
    output logic [TAG_W-1:0]   winner_o,
    output logic               found_o
);

    int idx;

    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx[TAG_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_issue_arb.sv
// Round-robin issue arbiter sharing one 3-stage pipelined ALU between NUM_REQ
// requesters; tracks per-stage valid/tag and stalls the whole pipe on backpressure.
module alu_issue_arb
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = 16,
    parameter int NUM_REQ   = 2,
    parameter int TAG_W     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*REG_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*REG_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ*ALU_CTRL_W-1:0] req_ctrl,
    input  logic [NUM_REQ-1:0]            req_cin,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [REG_WIDTH-1:0]          rsp_out,
    output logic                          rsp_cout,
    output logic [REG_WIDTH-1:0]          alu_a,
    output logic [REG_WIDTH-1:0]          alu_b,
    output logic [ALU_CTRL_W-1:0]         alu_ctrl,
    output logic                          alu_cin,
    output logic                          alu_pipe_active,
    input  logic [REG_WIDTH-1:0]          alu_out,
    input  logic                          alu_cout,
    output logic                          busy
);

    logic                  v0_q, v1_q, v2_q, v0_d, v1_d, v2_d;
    logic [TAG_W-1:0]      t0_q, t1_q, t2_q, t0_d, t1_d, t2_d;
    logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ALU_CTRL_W-1:0] cur_ctrl_q, cur_ctrl_d;
    logic                  cur_cin_q, cur_cin_d;

    logic [TAG_W-1:0]      win;
    logic                  found;
    logic [ALU_CTRL_W-1:0] win_ctrl;
    logic                  win_cin;
    logic                  eligible;
    logic                  adv;
    logic                  issue;
    logic [TAG_W-1:0]      ptr_inc;

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_rr_arb (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .winner_o (win),
        .found_o  (found)
    );

    assign win_ctrl = req_ctrl[win*ALU_CTRL_W +: ALU_CTRL_W];
    assign win_cin  = req_cin[win];

    // A changed ctrl/cin may only enter once nothing sits in the first two ALU
    // stages; the blocked winner is never bypassed, so the pipe drains instead.
    assign eligible = (!v0_q && !v1_q) || (win_ctrl == cur_ctrl_q && win_cin == cur_cin_q);
    assign adv      = !v2_q || rsp_ready[t2_q];
    assign issue    = reset_n && adv && found && eligible;
    assign ptr_inc  = (win == TAG_W'(NUM_REQ - 1)) ? '0 : win + TAG_W'(1);

    assign alu_pipe_active = reset_n && adv;
    assign alu_ctrl        = issue ? win_ctrl : cur_ctrl_q;
    assign alu_cin         = issue ? win_cin : cur_cin_q;
    assign alu_a           = issue ? req_a[win*REG_WIDTH +: REG_WIDTH] : '0;
    assign alu_b           = issue ? req_b[win*REG_WIDTH +: REG_WIDTH] : '0;

    assign rsp_out  = alu_out;
    assign rsp_cout = alu_cout;
    assign busy     = reset_n && (v0_q || v1_q || v2_q);

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (issue) begin
            req_ready[win] = 1'b1;
        end
        if (reset_n && v2_q) begin
            rsp_valid[t2_q] = 1'b1;
        end
    end

    always_comb begin
        v0_d       = v0_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        rr_ptr_d   = rr_ptr_q;
        cur_ctrl_d = cur_ctrl_q;
        cur_cin_d  = cur_cin_q;
        if (adv) begin
            v2_d = v1_q;
            t2_d = t1_q;
            v1_d = v0_q;
            t1_d = t0_q;
            v0_d = issue;
            t0_d = issue ? win : '0;
        end
        if (issue) begin
            rr_ptr_d   = ptr_inc;
            cur_ctrl_d = win_ctrl;
            cur_cin_d  = win_cin;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            t0_q       <= '0;
            t1_q       <= '0;
            t2_q       <= '0;
            rr_ptr_q   <= '0;
            cur_ctrl_q <= '0;
            cur_cin_q  <= 1'b0;
        end else begin
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_ctrl_q <= cur_ctrl_d;
            cur_cin_q  <= cur_cin_d;
        end
    end

endmodule
